// File: rtl/temp_fan_ctrl.sv
// temp_fan_ctrl: polls the SPI temperature sensor and drives the fan PWM.
// Ports: clk, reset (sync, active-high), sample_req, force_full,
//   TEMP_CS_n/TEMP_SCLK/TEMP_DIN/TEMP_DOUT (sensor SPI, CPOL=1),
//   FAN_CTRL (PWM), temp_value, temp_valid, sensor_err, fan_duty.
module temp_fan_ctrl #(
   parameter int unsigned        SCLK_DIV    = 25,
   parameter int unsigned        POLL_CYCLES = 50_000_000,
   parameter logic signed [13:0] T_LOW       = 14'sd1280,
   parameter logic signed [13:0] HYST        = 14'sd64,
   parameter logic [7:0]         DUTY_MIN    = 8'd96,
   parameter int unsigned        RAMP_SHIFT  = 2,
   parameter int unsigned        PWM_DIV     = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sample_req,
   input  logic        force_full,
   output logic        TEMP_CS_n,
   output logic        TEMP_SCLK,
   output logic        TEMP_DIN,
   input  logic        TEMP_DOUT,
   output logic        FAN_CTRL,
   output logic [13:0] temp_value,
   output logic        temp_valid,
   output logic        sensor_err,
   output logic [7:0]  fan_duty
);

   localparam int DIV_W  = $clog2(SCLK_DIV + 1);
   localparam int POLL_W = $clog2(POLL_CYCLES + 1);
   localparam int PRE_W  = $clog2(PWM_DIV + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCLK_DIV - 1);
   localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYCLES - 1);
   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PWM_DIV - 1);
   localparam logic signed [13:0] T_OFF    = T_LOW - HYST;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_HOLD,
      S_UPDATE
   } state_e;

   state_e state_q, state_d;

   logic [POLL_W-1:0] poll_q, poll_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [3:0]        bit_q, bit_d;
   logic              phase_q, phase_d;
   logic [15:0]       shift_q, shift_d;
   logic              cs_n_q, cs_n_d;
   logic              sclk_q, sclk_d;
   logic [13:0]       temp_q, temp_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic              fan_on_q, fan_on_d;
   logic [7:0]        duty_next_q, duty_next_d;
   logic [7:0]        duty_q, duty_d;
   logic [PRE_W-1:0]  pre_q, pre_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              pwm_q, pwm_d;

   logic              div_done;
   logic              pre_last;
   logic signed [13:0] frame_temp;
   logic signed [15:0] diff;
   logic [15:0]        ramp;
   logic [15:0]        sum;
   logic [7:0]         on_duty;

   // Duty for a fan that is on; readings at or below T_LOW get DUTY_MIN.
   assign frame_temp = shift_q[13:0];
   assign diff = {{2{frame_temp[13]}}, frame_temp} - {{2{T_LOW[13]}}, T_LOW};
   assign ramp = 16'(diff) >> RAMP_SHIFT;
   assign sum  = {8'd0, DUTY_MIN} + ramp;

   always_comb begin
      on_duty = DUTY_MIN;
      if (diff > 16'sd0) begin
         on_duty = (sum > 16'd255) ? 8'hFF : sum[7:0];
      end
   end

   assign div_done = (div_q == DIV_LAST);

   always_comb begin
      state_d     = state_q;
      poll_d      = poll_q;
      div_d       = div_q;
      bit_d       = bit_q;
      phase_d     = phase_q;
      shift_d     = shift_q;
      temp_d      = temp_q;
      valid_d     = 1'b0;
      err_d       = err_q;
      fan_on_d    = fan_on_q;
      duty_next_d = duty_next_q;
      unique case (state_q)
         S_IDLE: begin
            if (poll_q == '0 || sample_req) begin
               state_d = S_SETUP;
               poll_d  = POLL_LAST;
               div_d   = '0;
            end else begin
               poll_d = poll_q - POLL_W'(1);
            end
         end
         S_SETUP: begin
            if (div_done) begin
               state_d = S_SHIFT;
               div_d   = '0;
               bit_d   = '0;
               phase_d = 1'b0;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         S_SHIFT: begin
            if (div_done) begin
               div_d = '0;
               if (!phase_q) begin
                  // SCLK rises on this edge: capture DOUT.
                  phase_d = 1'b1;
                  shift_d = {shift_q[14:0], TEMP_DOUT};
               end else begin
                  phase_d = 1'b0;
                  if (bit_q == 4'd15) begin
                     state_d = S_HOLD;
                  end else begin
                     bit_d = bit_q + 4'd1;
                  end
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         S_HOLD: begin
            if (div_done) begin
               state_d = S_UPDATE;
               div_d   = '0;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         S_UPDATE: begin
            state_d = S_IDLE;
            if (shift_q[15:14] == 2'b00) begin
               temp_d  = frame_temp;
               valid_d = 1'b1;
               err_d   = 1'b0;
               if (frame_temp >= T_LOW) begin
                  fan_on_d = 1'b1;
               end else if (frame_temp < T_OFF) begin
                  fan_on_d = 1'b0;
               end
               duty_next_d = fan_on_d ? on_duty : 8'd0;
            end else begin
               // Malformed frame: run the fan flat out.
               err_d       = 1'b1;
               duty_next_d = 8'hFF;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      cs_n_d = (state_d == S_IDLE) || (state_d == S_UPDATE);
      sclk_d = !((state_d == S_SHIFT) && !phase_d);
   end

   // PWM; a new duty is taken only at the counter wrap.
   assign pre_last = (pre_q == PRE_LAST);

   always_comb begin
      pre_d  = pre_last ? '0 : pre_q + PRE_W'(1);
      cnt_d  = pre_last ? cnt_q + 8'd1 : cnt_q;
      duty_d = (pre_last && cnt_q == 8'hFF) ? duty_next_q : duty_q;
      pwm_d  = (cnt_d < duty_d) || (duty_d == 8'hFF);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         poll_q      <= '0;
         div_q       <= '0;
         bit_q       <= '0;
         phase_q     <= 1'b0;
         shift_q     <= '0;
         cs_n_q      <= 1'b1;
         sclk_q      <= 1'b1;
         temp_q      <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         fan_on_q    <= 1'b1;
         duty_next_q <= 8'hFF;
         duty_q      <= 8'hFF;
         pre_q       <= '0;
         cnt_q       <= '0;
         pwm_q       <= 1'b1;
      end else begin
         state_q     <= state_d;
         poll_q      <= poll_d;
         div_q       <= div_d;
         bit_q       <= bit_d;
         phase_q     <= phase_d;
         shift_q     <= shift_d;
         cs_n_q      <= cs_n_d;
         sclk_q      <= sclk_d;
         temp_q      <= temp_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
         fan_on_q    <= fan_on_d;
         duty_next_q <= duty_next_d;
         duty_q      <= duty_d;
         pre_q       <= pre_d;
         cnt_q       <= cnt_d;
         pwm_q       <= pwm_d;
      end
   end

   assign TEMP_CS_n  = cs_n_q;
   assign TEMP_SCLK  = sclk_q;
   assign TEMP_DIN   = 1'b0;
   assign FAN_CTRL   = pwm_q | force_full;
   assign temp_value = temp_q;
   assign temp_valid = valid_q;
   assign sensor_err = err_q;
   assign fan_duty   = duty_q;

endmodule

// File: tb/tb_temp_fan_ctrl.sv
// tb_temp_fan_ctrl: directed bench for temp_fan_ctrl.
// A behavioural SPI sensor model serves one 16-bit word per frame.
module tb_temp_fan_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sample_req = 1'b0;
   logic        force_full = 1'b0;
   logic        TEMP_CS_n;
   logic        TEMP_SCLK;
   logic        TEMP_DIN;
   logic        TEMP_DOUT = 1'b0;
   logic        FAN_CTRL;
   logic [13:0] temp_value;
   logic        temp_valid;
   logic        sensor_err;
   logic [7:0]  fan_duty;

   int checks = 0;
   int errors = 0;

   logic [15:0] sensor_word = 16'h0000;
   int          bidx = 15;

   temp_fan_ctrl #(
      .POLL_CYCLES(20000)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sample_req(sample_req),
      .force_full(force_full),
      .TEMP_CS_n (TEMP_CS_n),
      .TEMP_SCLK (TEMP_SCLK),
      .TEMP_DIN  (TEMP_DIN),
      .TEMP_DOUT (TEMP_DOUT),
      .FAN_CTRL  (FAN_CTRL),
      .temp_value(temp_value),
      .temp_valid(temp_valid),
      .sensor_err(sensor_err),
      .fan_duty  (fan_duty)
   );

   always #10 clk = ~clk;

   // Sensor: MSB first, next bit driven on each SCLK falling edge.
   always @(negedge TEMP_CS_n) bidx = 15;
   always @(negedge TEMP_SCLK) begin
      if (TEMP_CS_n === 1'b0 && bidx >= 0) begin
         TEMP_DOUT = sensor_word[bidx];
         bidx = bidx - 1;
      end
   end

   // Starts a frame (reset release or sample_req) and follows it to the end.
   task automatic do_frame(input logic [15:0] w, input bit use_req,
                           output int cs_low, output int vcnt);
      int to;
      sensor_word = w;
      if (use_req) begin
         sample_req = 1'b1;
         @(negedge clk);
         sample_req = 1'b0;
      end else begin
         reset = 1'b0;
         @(negedge clk);
      end
      to = 0;
      while (TEMP_CS_n !== 1'b0 && to < 200) begin
         @(negedge clk);
         to++;
      end
      cs_low = 0;
      while (TEMP_CS_n === 1'b0 && cs_low < 2000) begin
         cs_low++;
         @(negedge clk);
      end
      vcnt = 0;
      repeat (4) begin
         if (temp_valid === 1'b1) vcnt++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (TEMP_CS_n !== 1'b1 || TEMP_SCLK !== 1'b1 || TEMP_DIN !== 1'b0) begin
         errors++;
         $display("FAIL reset_spi got cs=%b sclk=%b din=%b want 1 1 0",
                  TEMP_CS_n, TEMP_SCLK, TEMP_DIN);
      end
      checks++;
      if (temp_value !== 14'd0 || temp_valid !== 1'b0 || sensor_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_status got val=%0d v=%b err=%b want 0 0 0",
                  temp_value, temp_valid, sensor_err);
      end
      checks++;
      if (fan_duty !== 8'd255 || FAN_CTRL !== 1'b1) begin
         errors++;
         $display("FAIL reset_fan got duty=%0d fan=%b want 255 1",
                  fan_duty, FAN_CTRL);
      end
   endtask

   task automatic test_nominal;
      int cs, v, hi;
      do_frame(16'h0500, 1'b0, cs, v);
      checks++;
      if (cs !== 850) begin
         errors++;
         $display("FAIL nominal_cs_low got %0d want 850", cs);
      end
      checks++;
      if (v !== 1) begin
         errors++;
         $display("FAIL nominal_valid got %0d pulses want 1", v);
      end
      checks++;
      if (temp_value !== 14'd1280 || sensor_err !== 1'b0) begin
         errors++;
         $display("FAIL nominal_value got %0d err=%b want 1280 0",
                  temp_value, sensor_err);
      end
      repeat (2100) @(negedge clk);
      checks++;
      if (fan_duty !== 8'd96) begin
         errors++;
         $display("FAIL nominal_duty got %0d want 96", fan_duty);
      end
      hi = 0;
      repeat (2048) begin
         if (FAN_CTRL === 1'b1) hi++;
         @(negedge clk);
      end
      checks++;
      if (hi !== 768) begin
         errors++;
         $display("FAIL nominal_pwm_high got %0d want 768", hi);
      end
   endtask

   task automatic test_hot;
      int cs, v, lo;
      do_frame(16'h0540, 1'b1, cs, v);
      repeat (2100) @(negedge clk);
      checks++;
      if (fan_duty !== 8'd112) begin
         errors++;
         $display("FAIL ramp_duty got %0d want 112", fan_duty);
      end
      do_frame(16'h0780, 1'b1, cs, v);
      checks++;
      if (temp_value !== 14'd1920 || v !== 1) begin
         errors++;
         $display("FAIL hot_value got %0d v=%0d want 1920 1", temp_value, v);
      end
      repeat (2100) @(negedge clk);
      checks++;
      if (fan_duty !== 8'd255) begin
         errors++;
         $display("FAIL hot_duty got %0d want 255", fan_duty);
      end
      lo = 0;
      repeat (600) begin
         if (FAN_CTRL !== 1'b1) lo++;
         @(negedge clk);
      end
      checks++;
      if (lo !== 0) begin
         errors++;
         $display("FAIL hot_fan_low got %0d low cycles want 0", lo);
      end
   endtask

   task automatic test_hysteresis;
      int cs, v, hi;
      logic [15:0] words [3];
      logic [13:0] temps [3];
      logic [7:0]  duties [3];
      words[0] = 16'h0500; temps[0] = 14'd1280; duties[0] = 8'd96;
      words[1] = 16'h04CE; temps[1] = 14'd1230; duties[1] = 8'd96;
      words[2] = 16'h04B0; temps[2] = 14'd1200; duties[2] = 8'd0;
      for (int i = 0; i < 3; i++) begin
         do_frame(words[i], 1'b1, cs, v);
         checks++;
         if (temp_value !== temps[i]) begin
            errors++;
            $display("FAIL hyst_value[%0d] got %0d want %0d",
                     i, temp_value, temps[i]);
         end
         repeat (2100) @(negedge clk);
         checks++;
         if (fan_duty !== duties[i]) begin
            errors++;
            $display("FAIL hyst_duty[%0d] got %0d want %0d",
                     i, fan_duty, duties[i]);
         end
      end
      hi = 0;
      repeat (600) begin
         if (FAN_CTRL !== 1'b0) hi++;
         @(negedge clk);
      end
      checks++;
      if (hi !== 0) begin
         errors++;
         $display("FAIL hyst_fan_off got %0d high cycles want 0", hi);
      end
   endtask

   task automatic test_force_full;
      force_full = 1'b1;
      @(negedge clk);
      checks++;
      if (FAN_CTRL !== 1'b1) begin
         errors++;
         $display("FAIL force_full got %b want 1", FAN_CTRL);
      end
      force_full = 1'b0;
      @(negedge clk);
      checks++;
      if (FAN_CTRL !== 1'b0) begin
         errors++;
         $display("FAIL force_release got %b want 0", FAN_CTRL);
      end
   endtask

   task automatic test_negative;
      int cs, v;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      do_frame(16'h3F60, 1'b0, cs, v);
      checks++;
      if (temp_value !== 14'h3F60 || v !== 1) begin
         errors++;
         $display("FAIL neg_value got %0d v=%0d want -160 (16224) 1",
                  temp_value, v);
      end
      repeat (2100) @(negedge clk);
      checks++;
      if (fan_duty !== 8'd0) begin
         errors++;
         $display("FAIL neg_duty got %0d want 0", fan_duty);
      end
   endtask

   task automatic test_sensor_err;
      int cs, v;
      do_frame(16'hFFFF, 1'b1, cs, v);
      checks++;
      if (sensor_err !== 1'b1 || v !== 0) begin
         errors++;
         $display("FAIL err_flag got err=%b v=%0d want 1 0", sensor_err, v);
      end
      checks++;
      if (temp_value !== 14'h3F60) begin
         errors++;
         $display("FAIL err_hold got %0d want 16224", temp_value);
      end
      repeat (2100) @(negedge clk);
      checks++;
      if (fan_duty !== 8'd255) begin
         errors++;
         $display("FAIL err_duty got %0d want 255", fan_duty);
      end
      do_frame(16'h0500, 1'b1, cs, v);
      checks++;
      if (sensor_err !== 1'b0 || temp_value !== 14'd1280 || v !== 1) begin
         errors++;
         $display("FAIL err_clear got err=%b val=%0d v=%0d want 0 1280 1",
                  sensor_err, temp_value, v);
      end
      repeat (2100) @(negedge clk);
      checks++;
      if (fan_duty !== 8'd96) begin
         errors++;
         $display("FAIL err_clear_duty got %0d want 96", fan_duty);
      end
   endtask

   task automatic test_midshift_req;
      int to, n, lo;
      sensor_word = 16'h04CE;
      sample_req = 1'b1;
      @(negedge clk);
      sample_req = 1'b0;
      to = 0;
      while (TEMP_CS_n !== 1'b0 && to < 200) begin
         @(negedge clk);
         to++;
      end
      n = 0;
      while (TEMP_CS_n === 1'b0 && n < 2000) begin
         n++;
         sample_req = (n == 300);
         @(negedge clk);
      end
      sample_req = 1'b0;
      checks++;
      if (n !== 850) begin
         errors++;
         $display("FAIL midreq_cs_low got %0d want 850", n);
      end
      lo = 0;
      repeat (1500) begin
         if (TEMP_CS_n !== 1'b1) lo++;
         @(negedge clk);
      end
      checks++;
      if (lo !== 0) begin
         errors++;
         $display("FAIL midreq_queued got %0d cs low cycles want 0", lo);
      end
   endtask

   task automatic test_midshift_reset;
      int to, cs, v;
      sensor_word = 16'h04B0;
      sample_req = 1'b1;
      @(negedge clk);
      sample_req = 1'b0;
      to = 0;
      while (TEMP_CS_n !== 1'b0 && to < 200) begin
         @(negedge clk);
         to++;
      end
      repeat (313) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (TEMP_CS_n !== 1'b1 || TEMP_SCLK !== 1'b1) begin
         errors++;
         $display("FAIL midrst_abort got cs=%b sclk=%b want 1 1",
                  TEMP_CS_n, TEMP_SCLK);
      end
      @(negedge clk);
      do_frame(16'h0780, 1'b0, cs, v);
      checks++;
      if (cs !== 850 || v !== 1 || temp_value !== 14'd1920) begin
         errors++;
         $display("FAIL midrst_restart got cs=%0d v=%0d val=%0d want 850 1 1920",
                  cs, v, temp_value);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_hot();
      test_hysteresis();
      test_force_full();
      test_negative();
      test_sensor_err();
      test_midshift_req();
      test_midshift_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
